// File: rtl/imem_readback_check_pkg.sv
// rtl/imem_readback_check_pkg.sv - shared widths, FSM encoding and helpers for the readback checker
package imem_readback_check_pkg;

  localparam int FLASH_AW = 10;
  localparam int PROG_AW  = 8;
  localparam int INSTR_W  = 16;
  localparam int ERR_CW   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CW-1:0] sat_inc(input logic [ERR_CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/imem_readback_check.sv
// rtl/imem_readback_check.sv - compares loaded instruction memory against its flash image
module imem_readback_check
  import imem_readback_check_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int FLASH_BASE = 0
) (
  input  logic                clk_in,
  input  logic                rst_verify,
  input  logic                start,
  output logic                flash_en,
  output logic [FLASH_AW-1:0] flash_addr,
  input  logic [INSTR_W-1:0]  flash_do,
  output logic                im_rd_en,
  output logic [PROG_AW-1:0]  im_rd_addr,
  input  logic [INSTR_W-1:0]  im_rd_data,
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic [PROG_AW-1:0]  err_addr,
  output logic [ERR_CW-1:0]   err_count
);

  localparam logic [PROG_AW-1:0]  LAST_IDX  = PROG_AW'(DEPTH - 1);
  localparam logic [FLASH_AW-1:0] BASE_ADDR = FLASH_AW'(FLASH_BASE);

  state_t              r_state;
  state_t              w_next;
  logic [PROG_AW-1:0]  r_index;
  logic [PROG_AW-1:0]  r_cmp_addr;
  logic                r_cmp_valid;
  logic [ERR_CW-1:0]   r_err_count;
  logic [PROG_AW-1:0]  r_err_addr;
  logic                r_pass;
  logic                r_fail;
  logic                w_issue;
  logic                w_accept;
  logic                w_mismatch;

  // Both memories are addressed by the same index; flash is offset and wraps at 1024 words.
  assign flash_addr = BASE_ADDR + FLASH_AW'(r_index);
  assign im_rd_addr = r_index;
  assign flash_en   = w_issue;
  assign im_rd_en   = w_issue;

  // Read data from both memories lands one cycle after issue, tagged by the registered valid.
  assign w_mismatch = r_cmp_valid && (flash_do != im_rd_data);

  assign err_count = r_err_count;
  assign err_addr  = r_err_addr;
  assign pass      = r_pass;
  assign fail      = r_fail;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_verify) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the per-state strobes; start is only honoured in IDLE.
  always_comb begin
    w_next   = r_state;
    w_issue  = 1'b0;
    w_accept = 1'b0;
    busy     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE: begin
        busy    = 1'b1;
        w_issue = 1'b1;
        if (r_index == LAST_IDX) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Index walk, compare pipeline, error tally and sticky verdict.
  always_ff @(posedge clk_in) begin
    if (rst_verify) begin
      r_index     <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_addr  <= '0;
      r_err_count <= '0;
      r_err_addr  <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_cmp_valid <= w_issue;
      if (w_issue) begin
        r_cmp_addr <= r_index;
      end
      if (w_accept) begin
        r_index     <= '0;
        r_err_count <= '0;
        r_err_addr  <= '0;
        r_pass      <= 1'b0;
        r_fail      <= 1'b0;
      end else begin
        if (w_issue && (r_index != LAST_IDX)) begin
          r_index <= r_index + 1'b1;
        end
        if (w_mismatch) begin
          r_err_count <= sat_inc(r_err_count);
          if (r_err_count == '0) begin
            r_err_addr <= r_cmp_addr;
          end
        end
        if (r_state == DONE) begin
          r_pass <= (r_err_count == '0);
          r_fail <= (r_err_count != '0);
        end
      end
    end
  end

endmodule
